// File: rtl/prog_mem_pkg.sv
// Shared definitions for the multi-core program memory: default geometry,
// loader FSM state encoding and the parity helper used by the banks.
package prog_mem_pkg;

    localparam int DEF_DW    = 18;
    localparam int DEF_AW    = 12;
    localparam int DEF_NCORE = 2;

    // Parity helper operates on a fixed-width zero-extended operand.
    localparam int PAR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/prog_mem_mc_if.sv
// Loader and per-core read bus of the multi-core program memory.
// master = host/boot FSM plus the cores, slave = the memory.
interface prog_mem_mc_if #(
    parameter int DW    = 18,
    parameter int AW    = 12,
    parameter int NCORE = 2
) ();
    logic                   LD_START;
    logic [AW-1:0]          LD_BASE;
    logic [AW:0]            LD_LEN;
    logic                   LD_VALID;
    logic [DW-1:0]          LD_DATA;
    logic                   LD_READY;
    logic                   LD_BUSY;
    logic                   LD_DONE;
    logic [NCORE-1:0]       RD_EN;
    logic [NCORE*AW-1:0]    RD_ADDR;
    logic [NCORE*DW-1:0]    RD_DATA;
    logic [NCORE-1:0]       RD_VALID;
    logic [NCORE-1:0]       PAR_ERR;

    modport master (
        output LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, RD_EN, RD_ADDR,
        input  LD_READY, LD_BUSY, LD_DONE, RD_DATA, RD_VALID, PAR_ERR
    );

    modport slave (
        input  LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, RD_EN, RD_ADDR,
        output LD_READY, LD_BUSY, LD_DONE, RD_DATA, RD_VALID, PAR_ERR
    );
endinterface

// File: rtl/prog_mem_bank.sv
// One simple-dual-port block RAM copy of the program image with a registered
// read port. Optional stored parity bit when PROG_MEM_PARITY_EN is defined.
module prog_mem_bank
    import prog_mem_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          par_err
);
    localparam int MEM_SIZE = 1 << AW;

`ifdef PROG_MEM_PARITY_EN
    localparam int BW = DW + 1;
`else
    localparam int BW = DW;
`endif

    (* ram_style = "block" *) logic [BW-1:0] mem [MEM_SIZE];

    logic [BW-1:0] wword;
    logic [BW-1:0] rword_reg;
    logic          rvalid_reg;

`ifdef PROG_MEM_PARITY_EN
    assign wword = {even_parity(PAR_MAX_W'(wdata)), wdata};
`else
    assign wword = wdata;
`endif

    // Contents are deliberately untouched by reset so the image survives it.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wword;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rword_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= re;
            if (re) begin
                rword_reg <= mem[raddr];
            end
        end
    end

    assign rdata  = rword_reg[DW-1:0];
    assign rvalid = rvalid_reg;

`ifdef PROG_MEM_PARITY_EN
    assign par_err = rvalid_reg &
                     (even_parity(PAR_MAX_W'(rword_reg[DW-1:0])) != rword_reg[DW]);
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/prog_mem_mc.sv
// Multi-core program memory: NCORE replicated banks, burst loader FSM.
// Optional parity per word enabled by defining PROG_MEM_PARITY_EN.
module prog_mem_mc
    import prog_mem_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int NCORE = DEF_NCORE
) (
    input  logic         CLK,
    input  logic         RST,
    prog_mem_mc_if.slave bus
);
    localparam int LW = AW + 1;

    ld_state_t     state_reg;
    logic          ready_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [AW-1:0] addr_reg;
    logic [LW-1:0] cnt_reg;
    logic          wr_en;

    // A word arriving in the same cycle as reset is dropped with the burst.
    assign wr_en = ready_reg & bus.LD_VALID & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.LD_START) begin
                        addr_reg <= bus.LD_BASE;
                        cnt_reg  <= bus.LD_LEN;
                        busy_reg <= 1'b1;
                        if (bus.LD_LEN != '0) begin
                            state_reg <= LOAD;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.LD_VALID) begin
                        addr_reg <= addr_reg + 1'b1;
                        cnt_reg  <= cnt_reg - 1'b1;
                        if (cnt_reg == LW'(1)) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LD_READY = ready_reg;
    assign bus.LD_BUSY  = busy_reg;
    assign bus.LD_DONE  = done_reg;

    // Reads are blocked for the whole burst, so a bank never sees a
    // read and a write in the same cycle.
    generate
        for (genvar gi = 0; gi < NCORE; gi++) begin : g_bank
            logic [DW-1:0] rdata;

            prog_mem_bank #(
                .DW (DW),
                .AW (AW)
            ) u_bank (
                .CLK     (CLK),
                .RST     (RST),
                .we      (wr_en),
                .waddr   (addr_reg),
                .wdata   (bus.LD_DATA),
                .re      (bus.RD_EN[gi] & ~busy_reg),
                .raddr   (bus.RD_ADDR[gi*AW +: AW]),
                .rdata   (rdata),
                .rvalid  (bus.RD_VALID[gi]),
                .par_err (bus.PAR_ERR[gi])
            );

            assign bus.RD_DATA[gi*DW +: DW] = rdata;
        end
    endgenerate

endmodule

// File: tb/tb_prog_mem_mc.sv
// Directed bench for prog_mem_mc: burst loads, wrap, zero length, busy
// blocking, reset abort, parity (when PROG_MEM_PARITY_EN) and full-size load.
module tb_prog_mem_mc;
    localparam int DW       = 18;
    localparam int AW       = 12;
    localparam int NCORE    = 2;
    localparam int MEM_SIZE = 1 << AW;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] ld_buf [0:MEM_SIZE-1];

    prog_mem_mc_if #(.DW(DW), .AW(AW), .NCORE(NCORE)) bus ();

    prog_mem_mc #(.DW(DW), .AW(AW), .NCORE(NCORE)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [DW-1:0] rd_word(input int i);
        return bus.RD_DATA[i*DW +: DW];
    endfunction

    function automatic logic [2:0] ld_flags();
        return {bus.LD_BUSY, bus.LD_DONE, bus.LD_READY};
    endfunction

    // Burst of n words from ld_buf with LD_VALID held high throughout.
    task automatic load_burst(input string tag, input logic [AW-1:0] base, input int n);
        int idx = 0;
        int cyc = 0;
        int rdy = 0;
        int dn  = 0;
        bus.LD_START = 1'b1;
        bus.LD_BASE  = base;
        bus.LD_LEN   = (AW+1)'(n);
        bus.LD_VALID = 1'b0;
        tick();
        bus.LD_START = 1'b0;
        while (idx < n && cyc < n + 16) begin
            bus.LD_VALID = 1'b1;
            bus.LD_DATA  = ld_buf[idx];
            if (bus.LD_READY) begin
                rdy++;
                idx++;
            end
            tick();
            cyc++;
            if (bus.LD_DONE) dn++;
        end
        bus.LD_VALID = 1'b0;
        check({tag, "_words"}, 64'(idx), 64'(n));
        check({tag, "_ready_cycles"}, 64'(rdy), 64'(n));
        check({tag, "_done_pulses"}, 64'(dn), 64'd1);
        tick();
        check({tag, "_idle_flags"}, 64'(ld_flags()), 64'd0);
    endtask

    task automatic read2(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.RD_EN   = en;
        bus.RD_ADDR = {a1, a0};
        tick();
        bus.RD_EN   = '0;
    endtask

    initial begin
        bus.LD_START = 1'b0;
        bus.LD_BASE  = '0;
        bus.LD_LEN   = '0;
        bus.LD_VALID = 1'b0;
        bus.LD_DATA  = '0;
        bus.RD_EN    = '0;
        bus.RD_ADDR  = '0;

        // Reset state
        tick();
        tick();
        check("rst_flags", 64'(ld_flags()), 64'd0);
        check("rst_rd_valid", 64'(bus.RD_VALID), 64'd0);
        check("rst_rd_data", 64'(bus.RD_DATA), 64'd0);
        check("rst_par_err", 64'(bus.PAR_ERR), 64'd0);
        RST = 1'b0;
        tick();

        // Basic 4-word burst, then core0 reads back one word
        for (int k = 0; k < 4; k++) ld_buf[k] = DW'(k + 1);
        load_burst("t1", 12'h010, 4);
        read2(2'b01, 12'h012, 12'h000);
        check("t1_rd_valid", 64'(bus.RD_VALID), 64'b01);
        check("t1_rd_data0", 64'(rd_word(0)), 64'h00003);

        // Address wrap at top of memory
        ld_buf[0] = 18'h2AAAA;
        ld_buf[1] = 18'h15555;
        ld_buf[2] = 18'h3C3C3;
        ld_buf[3] = 18'h00F0F;
        load_burst("t2", 12'hFFE, 4);
        read2(2'b11, 12'hFFE, 12'hFFF);
        check("t2_mem_ffe", 64'(rd_word(0)), 64'h2AAAA);
        check("t2_mem_fff", 64'(rd_word(1)), 64'h15555);
        read2(2'b11, 12'h000, 12'h001);
        check("t2_mem_000", 64'(rd_word(0)), 64'h3C3C3);
        check("t2_mem_001", 64'(rd_word(1)), 64'h00F0F);

        // Zero-length burst: straight to DONE, nothing written
        bus.LD_START = 1'b1;
        bus.LD_BASE  = 12'h010;
        bus.LD_LEN   = '0;
        tick();
        bus.LD_START = 1'b0;
        check("t3_len0_done_flags", 64'(ld_flags()), 64'b110);
        tick();
        check("t3_len0_idle_flags", 64'(ld_flags()), 64'd0);
        read2(2'b01, 12'h010, 12'h000);
        check("t3_len0_mem_010", 64'(rd_word(0)), 64'h00001);

        // Second LD_START during LOAD ignored; LD_VALID low stalls
        bus.LD_START = 1'b1;
        bus.LD_BASE  = 12'h020;
        bus.LD_LEN   = 13'd2;
        tick();
        bus.LD_BASE  = 12'h100;
        bus.LD_LEN   = 13'd5;
        tick();
        bus.LD_START = 1'b0;
        check("t3_stall_flags", 64'(ld_flags()), 64'b101);
        bus.LD_VALID = 1'b1;
        bus.LD_DATA  = 18'h11111;
        tick();
        bus.LD_DATA  = 18'h22222;
        tick();
        bus.LD_VALID = 1'b0;
        check("t3_restart_done", 64'(ld_flags()), 64'b110);
        tick();
        check("t3_restart_idle", 64'(ld_flags()), 64'd0);
        read2(2'b11, 12'h020, 12'h021);
        check("t3_mem_020", 64'(rd_word(0)), 64'h11111);
        check("t3_mem_021", 64'(rd_word(1)), 64'h22222);

        // Two cores in one cycle, then reads blocked during a load
        ld_buf[0] = 18'h33333;
        load_burst("t4a", 12'h003, 1);
        ld_buf[0] = 18'h17FF7;
        load_burst("t4b", 12'h7FF, 1);
        read2(2'b11, 12'h003, 12'h7FF);
        check("t4_rd_valid", 64'(bus.RD_VALID), 64'b11);
        check("t4_core0", 64'(rd_word(0)), 64'h33333);
        check("t4_core1", 64'(rd_word(1)), 64'h17FF7);
        bus.LD_START = 1'b1;
        bus.LD_BASE  = 12'h400;
        bus.LD_LEN   = 13'd1;
        tick();
        bus.LD_START = 1'b0;
        read2(2'b11, 12'h010, 12'h012);
        check("t4_busy_rd_valid", 64'(bus.RD_VALID), 64'b00);
        check("t4_busy_hold0", 64'(rd_word(0)), 64'h33333);
        bus.LD_VALID = 1'b1;
        bus.LD_DATA  = 18'h0ABCD;
        tick();
        bus.LD_VALID = 1'b0;
        check("t4_load_done", 64'(ld_flags()), 64'b110);
        tick();

        // Reset after 2 of 5 words
        bus.LD_START = 1'b1;
        bus.LD_BASE  = 12'h200;
        bus.LD_LEN   = 13'd5;
        tick();
        bus.LD_START = 1'b0;
        bus.LD_VALID = 1'b1;
        bus.LD_DATA  = 18'h2AA02;
        tick();
        bus.LD_DATA  = 18'h2AA03;
        tick();
        bus.LD_VALID = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_rst_flags", 64'(ld_flags()), 64'd0);
        tick();
        check("t5_no_done", 64'(ld_flags()), 64'd0);
        read2(2'b11, 12'h200, 12'h201);
        check("t5_mem_200", 64'(rd_word(0)), 64'h2AA02);
        check("t5_mem_201", 64'(rd_word(1)), 64'h2AA03);

`ifdef PROG_MEM_PARITY_EN
        read2(2'b11, 12'h200, 12'h200);
        check("t6_clean_valid", 64'(bus.RD_VALID), 64'b11);
        check("t6_clean_par", 64'(bus.PAR_ERR), 64'b00);
        dut.g_bank[1].u_bank.mem[12'h201][0] = ~dut.g_bank[1].u_bank.mem[12'h201][0];
        read2(2'b11, 12'h201, 12'h201);
        check("t6_flip_valid", 64'(bus.RD_VALID), 64'b11);
        check("t6_flip_par", 64'(bus.PAR_ERR), 64'b10);
        check("t6_flip_data1", 64'(rd_word(1)), 64'h2AA02);
        check("t6_flip_data0", 64'(rd_word(0)), 64'h2AA03);
`else
        read2(2'b11, 12'h200, 12'h201);
        check("t6_par_off", 64'(bus.PAR_ERR), 64'b00);
`endif

        // Full-size burst wraps back to its base
        for (int k = 0; k < MEM_SIZE; k++) ld_buf[k] = DW'(k);
        load_burst("t7", 12'h800, MEM_SIZE);
        read2(2'b11, 12'h800, 12'h7FF);
        check("t7_mem_800", 64'(rd_word(0)), 64'h000);
        check("t7_mem_7ff", 64'(rd_word(1)), 64'hFFF);
        read2(2'b11, 12'h000, 12'hFFF);
        check("t7_mem_000", 64'(rd_word(0)), 64'h800);
        check("t7_mem_fff", 64'(rd_word(1)), 64'h7FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
